// File: rtl/spi_txn_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_txn_arbiter_if                                               |
// | Requester and SPI-master signal bundle for spi_txn_arbiter.      |
// | slave  : the arbiter side (drives grants, strobes, rx byte)      |
// | master : the environment side (drives requests, tx bytes, MISO)  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface spi_txn_arbiter_if;
  // requester side
  logic [1:0] req;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] rx_data;
  logic       busy;
  // SPI master side
  logic       spi_start;
  logic       spi_load;
  logic       spi_read;
  logic [7:0] spi_data_in;
  logic [7:0] spi_data_out;

  modport slave (
    input  req, tx_data0, tx_data1, spi_data_out,
    output gnt, done, rx_data, busy,
    output spi_start, spi_load, spi_read, spi_data_in
  );

  modport master (
    output req, tx_data0, tx_data1, spi_data_out,
    input  gnt, done, rx_data, busy,
    input  spi_start, spi_load, spi_read, spi_data_in
  );
endinterface
`default_nettype wire

// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_txn_arbiter                                                  |
// | Round-robin arbiter sharing one SPI master between two           |
// | requesters. Each granted transaction runs LOAD, SHIFT x N,       |
// | LATCH, CAPTURE, DONE and an optional idle GAP.                   |
// | SHIFT_CYCLES legal range 1..8, GAP_CYCLES legal range 0..15.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module spi_txn_arbiter #(
  parameter int unsigned SHIFT_CYCLES = 8,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input wire               sclk,
  input wire               reset,
  spi_txn_arbiter_if.slave bus
);

  // Terminal counts for the shared 4-bit phase counter.
  localparam logic [3:0] SHIFT_LAST = 4'(SHIFT_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    LATCH   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5,
    GAP     = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       cnt_run;
  logic       last_served;   // 1: requester 1 was served most recently
  logic [1:0] winner;
  logic [1:0] gnt_q;
  logic [7:0] rx_q;
  logic       start_c;
  logic       load_c;
  logic       read_c;
  logic [7:0] data_in_c;
  logic [1:0] done_c;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    winner = 2'b00;
    if (bus.req == 2'b11) begin
      winner = last_served ? 2'b01 : 2'b10;
    end else if (bus.req[0]) begin
      winner = 2'b01;
    end else if (bus.req[1]) begin
      winner = 2'b10;
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and SPI strobe decode.
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    load_c    = 1'b0;
    read_c    = 1'b0;
    data_in_c = 8'h00;
    done_c    = 2'b00;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        start_c   = 1'b1;
        load_c    = 1'b1;
        // The SPI master captures this byte at the end of LOAD, so later
        // tx_data changes cannot reach the current transaction.
        data_in_c = gnt_q[1] ? bus.tx_data1 : bus.tx_data0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        start_c = 1'b1;
        if (cnt == SHIFT_LAST) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        start_c   = 1'b1;
        read_c    = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        start_c   = 1'b1;
        read_c    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done_c    = gnt_q;
        state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The counter restarts from zero on entry to SHIFT or GAP.
  assign cnt_run = ((state == SHIFT) && (state_nxt == SHIFT)) ||
                   ((state == GAP)   && (state_nxt == GAP));

  // Phase counter shared by SHIFT and GAP.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (cnt_run) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= 4'd0;
    end
  end

  // Grant is set leaving IDLE and dropped at the end of DONE.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      gnt_q <= 2'b00;
    end else if ((state == IDLE) && (|bus.req)) begin
      gnt_q <= winner;
    end else if (state == DONE) begin
      gnt_q <= 2'b00;
    end
  end

  // Remember who was served; starts at 1 so requester 0 wins first.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      last_served <= 1'b1;
    end else if ((state == IDLE) && (|bus.req)) begin
      last_served <= winner[1];
    end
  end

  // Received byte is taken at the end of CAPTURE and held until the next one.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      rx_q <= 8'h00;
    end else if (state == CAPTURE) begin
      rx_q <= bus.spi_data_out;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_c;
  assign bus.rx_data     = rx_q;
  assign bus.busy        = (state != IDLE);
  assign bus.spi_start   = start_c;
  assign bus.spi_load    = load_c;
  assign bus.spi_read    = read_c;
  assign bus.spi_data_in = data_in_c;

endmodule
`default_nettype wire
